// File: rtl/alu_seq_multiplier_if.sv
// Handshake and data bundle for the sequential multiplier.
// The master issues operands and start; the slave returns status and product.
interface alu_seq_multiplier_if #(
    parameter int W = 32
);
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Radix-2 shift-add multiplier: W RUN cycles, then a one-cycle done strobe.
// Signed operands are multiplied as magnitudes and the sign applied at the end.
module alu_seq_multiplier #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_seq_multiplier_if.slave   m
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic           neg;
    logic           busy_q;
    logic           done_q;
    logic [2*W-1:0] prod_q;

    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] acc_nxt;
    logic [2*W-1:0] prod_nxt;

    // |x| as a W-bit unsigned value; the most negative value maps onto itself
    assign mag_a = (m.signed_mode && m.a[W-1]) ? -m.a : m.a;
    assign mag_b = (m.signed_mode && m.b[W-1]) ? -m.b : m.b;

    // Accumulator value after the current multiplier bit is consumed
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign prod_nxt = neg ? -acc_nxt : acc_nxt;

    assign m.busy    = busy_q;
    assign m.done    = done_q;
    assign m.product = prod_q;

    // Control FSM and datapath; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            prod_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (m.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{W{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= m.signed_mode & (m.a[W-1] ^ m.b[W-1]);
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        prod_q <= prod_nxt;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Scoreboard bench for alu_seq_multiplier at W=32 and W=8.
// Stimulus queues expected products; per-DUT monitors pop them on done.
module tb_alu_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_seq_multiplier_if #(.W(32)) if32 ();
    alu_seq_multiplier_if #(.W(8))  if8 ();

    alu_seq_multiplier #(.W(32)) u32 (
        .clk (clk),
        .rst (rst),
        .m   (if32)
    );

    alu_seq_multiplier #(.W(8)) u8 (
        .clk (clk),
        .rst (rst),
        .m   (if8)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] q32 [$];
    logic [15:0] q8  [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // Monitor for the W=32 instance
    initial begin : mon32
        logic        rp;
        logic [63:0] model;
        logic [63:0] e;
        rp    = 1'b1;
        model = '0;
        forever begin
            @(negedge clk);
            chk("busy_done_excl32", 64'(if32.busy & if32.done), 64'd0);
            if (rp) begin
                chk("rst_prod32", if32.product, 64'd0);
                chk("rst_ctl32", 64'({if32.busy, if32.done}), 64'd0);
                model = '0;
            end else if (if32.done === 1'b1) begin
                if (q32.size() == 0) begin
                    flag("unexpected_done32");
                end else begin
                    e = q32.pop_front();
                    chk("product32", if32.product, e);
                    model = e;
                end
            end else begin
                chk("hold32", if32.product, model);
            end
            rp = rst;
        end
    end

    // Monitor for the W=8 instance
    initial begin : mon8
        logic        rp;
        logic [15:0] model;
        logic [15:0] e;
        rp    = 1'b1;
        model = '0;
        forever begin
            @(negedge clk);
            chk("busy_done_excl8", 64'(if8.busy & if8.done), 64'd0);
            if (rp) begin
                chk("rst_prod8", 64'(if8.product), 64'd0);
                chk("rst_ctl8", 64'({if8.busy, if8.done}), 64'd0);
                model = '0;
            end else if (if8.done === 1'b1) begin
                if (q8.size() == 0) begin
                    flag("unexpected_done8");
                end else begin
                    e = q8.pop_front();
                    chk("product8", 64'(if8.product), 64'(e));
                    model = e;
                end
            end else begin
                chk("hold8", 64'(if8.product), 64'(model));
            end
            rp = rst;
        end
    end

    // Issue one W=32 operation; optionally check the exact busy/done timing
    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input logic [63:0] exp,
                         input bit lat);
        bit bad;
        bit seen;
        if32.a           = a;
        if32.b           = b;
        if32.signed_mode = sm;
        if32.start       = 1'b1;
        q32.push_back(exp);
        @(posedge clk);
        #1;
        if32.start       = 1'b0;
        if32.a           = $urandom;
        if32.b           = $urandom;
        if32.signed_mode = ~sm;
        if (lat) begin
            bad = 1'b0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (!(if32.busy === 1'b1 && if32.done === 1'b0))
                    bad = 1'b1;
            end
            chk("busy_window32", 64'(bad), 64'd0);
            @(negedge clk);
            chk("done_timing32", 64'({if32.busy, if32.done}), 64'd1);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (if32.done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen)
                flag("timeout_done32");
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one W=8 operation; optionally check the exact busy/done timing
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [15:0] exp,
                        input bit lat);
        bit bad;
        bit seen;
        if8.a           = a;
        if8.b           = b;
        if8.signed_mode = sm;
        if8.start       = 1'b1;
        q8.push_back(exp);
        @(posedge clk);
        #1;
        if8.start       = 1'b0;
        if8.a           = 8'($urandom);
        if8.b           = 8'($urandom);
        if8.signed_mode = ~sm;
        if (lat) begin
            bad = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (!(if8.busy === 1'b1 && if8.done === 1'b0))
                    bad = 1'b1;
            end
            chk("busy_window8", 64'(bad), 64'd0);
            @(negedge clk);
            chk("done_timing8", 64'({if8.busy, if8.done}), 64'd1);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (if8.done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen)
                flag("timeout_done8");
        end
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus
    initial begin : stim
        bit bad;
        bit seen;
        if32.start       = 1'b0;
        if32.signed_mode = 1'b0;
        if32.a           = '0;
        if32.b           = '0;
        if8.start        = 1'b0;
        if8.signed_mode  = 1'b0;
        if8.a            = '0;
        if8.b            = '0;
        rst              = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ctl32", 64'({if32.busy, if32.done}), 64'd0);
            chk("idle_ctl8", 64'({if8.busy, if8.done}), 64'd0);
        end
        @(posedge clk);
        #1;

        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              64'hFFFF_FFFE_0000_0001, 1'b1);
        run32(32'hFFFF_FFF9, 32'd6, 1'b1,
              64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1,
              64'h4000_0000_0000_0000, 1'b0);
        run32(32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0, 1'b0);
        run32(32'd12345, 32'd678, 1'b0, 64'd8369910, 1'b0);

        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        run8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
        run8(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0);
        run8(8'hFD, 8'hFB, 1'b1, 16'd15, 1'b0);

        // start pulse during RUN must be ignored
        if8.a           = 8'd3;
        if8.b           = 8'd5;
        if8.signed_mode = 1'b0;
        if8.start       = 1'b1;
        q8.push_back(16'd15);
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if8.a           = 8'd9;
        if8.b           = 8'd9;
        if8.signed_mode = 1'b1;
        if8.start       = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        if8.a     = 8'hA5;
        if8.b     = 8'h3C;
        seen      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (if8.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            flag("timeout_ignore8");

        // back-to-back: start held in the DONE cycle
        if8.a           = 8'd2;
        if8.b           = 8'd4;
        if8.signed_mode = 1'b0;
        if8.start       = 1'b1;
        q8.push_back(16'd8);
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        chk("b2b_busy8", 64'(if8.busy), 64'd1);
        bad = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            if (if8.done !== (j == 8))
                bad = 1'b1;
        end
        chk("b2b_done_at_9", 64'(bad), 64'd0);
        @(posedge clk);
        #1;

        // reset during RUN cycle 4 aborts without a done strobe
        if8.a           = 8'd10;
        if8.b           = 8'd10;
        if8.signed_mode = 1'b0;
        if8.start       = 1'b1;
        q8.push_back(16'd100);
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ctl8", 64'({if8.busy, if8.done}), 64'd0);
        chk("abort_prod8", 64'(if8.product), 64'd0);
        q8.delete();
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done !== 1'b0)
                bad = 1'b1;
        end
        chk("abort_no_done8", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        run8(8'd10, 8'd10, 1'b0, 16'd100, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("drained32", 64'(q32.size()), 64'd0);
        chk("drained8", 64'(q8.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
